// File: rtl/dvi_pattern_pkg.sv
// Shared pattern codes, colour constants and the colour-bar palette lookup
// for the DVI test-pattern source.
package dvi_pattern_pkg;

   typedef enum logic [2:0] {
      PAT_BARS    = 3'd0,
      PAT_CHECKER = 3'd1,
      PAT_HRAMP   = 3'd2,
      PAT_VRAMP   = 3'd3,
      PAT_BOX     = 3'd4,
      PAT_BORDER  = 3'd5,
      PAT_WHITE   = 3'd6,
      PAT_BLACK   = 3'd7
   } pattern_e;

   typedef logic [23:0] rgb_t;

   localparam rgb_t COL_WHITE   = 24'hFFFFFF;
   localparam rgb_t COL_YELLOW  = 24'hFFFF00;
   localparam rgb_t COL_CYAN    = 24'h00FFFF;
   localparam rgb_t COL_GREEN   = 24'h00FF00;
   localparam rgb_t COL_MAGENTA = 24'hFF00FF;
   localparam rgb_t COL_RED     = 24'hFF0000;
   localparam rgb_t COL_BLUE    = 24'h0000FF;
   localparam rgb_t COL_BLACK   = 24'h000000;

   // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic rgb_t bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return COL_WHITE;
         3'd1:    return COL_YELLOW;
         3'd2:    return COL_CYAN;
         3'd3:    return COL_GREEN;
         3'd4:    return COL_MAGENTA;
         3'd5:    return COL_RED;
         3'd6:    return COL_BLUE;
         default: return COL_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/dvi_pattern_gen_if.sv
// Video link between the upstream timing generator, the pattern source and
// the TMDS encoder: timing strobes and coordinates in, aligned strobes and RGB out.
interface dvi_pattern_gen_if;
   logic       hsIn;
   logic       vsIn;
   logic       deIn;
   logic [9:0] pixelX;
   logic [9:0] pixelY;
   logic       hs;
   logic       vs;
   logic       de;
   logic [7:0] red;
   logic [7:0] green;
   logic [7:0] blue;

   // Timing side: drives strobes/coordinates, receives the coloured video.
   modport master (
      output hsIn, vsIn, deIn, pixelX, pixelY,
      input  hs, vs, de, red, green, blue
   );

   // Pattern source side.
   modport slave (
      input  hsIn, vsIn, deIn, pixelX, pixelY,
      output hs, vs, de, red, green, blue
   );
endinterface

// File: rtl/dvi_pattern_gen_bounce_counter.sv
// One axis of the bouncing box: steps one pixel per frame between 0 and MAX,
// reversing at either end and taking that frame's step in the new direction.
module bounce_counter #(
   parameter int MAX = 736
) (
   input  logic       pixelClk,
   input  logic       reset,
   input  logic       step,
   output logic [9:0] pos
);

   logic up;

   always_ff @(posedge pixelClk) begin
      if (reset) begin
         pos <= '0;
         up  <= 1'b1;
      end else if (step) begin
         if (up) begin
            if (pos == 10'(MAX)) begin
               up  <= 1'b0;
               pos <= pos - 10'd1;
            end else begin
               pos <= pos + 10'd1;
            end
         end else begin
            if (pos == 10'd0) begin
               up  <= 1'b1;
               pos <= pos + 10'd1;
            end else begin
               pos <= pos - 10'd1;
            end
         end
      end
   end

endmodule

// File: rtl/dvi_pattern_gen.sv
// Test-pattern pixel source: two-stage pipeline from timing strobes/coordinates
// to RGB, with pattern selection and box motion updated only at frame start.
module dvi_pattern_gen
   import dvi_pattern_pkg::*;
#(
   parameter int PIXELS_H           = 800,
   parameter int PIXELS_V           = 600,
   parameter int BAR_WIDTH          = 100,
   parameter int CHECK_LOG2         = 5,
   parameter int BOX_SIZE           = 64,
   parameter int FRAMES_PER_PATTERN = 120
) (
   input  logic                pixelClk,
   input  logic                reset,
   dvi_pattern_gen_if.slave    vid,
   input  logic [2:0]          patternSel,
   input  logic                autoCycle,
   output logic [2:0]          activePattern,
   output logic [15:0]         frameCount
);

   localparam int DIV_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;

   logic             hs1, vs1, de1;
   logic [9:0]       x1, y1;
   logic             frameStart;
   pattern_e         pattern;
   logic [DIV_W-1:0] divider;
   logic [9:0]       bx, by;
   logic [2:0]       barIdx;
   logic             inBox, onBorder;
   rgb_t             colour;

   // vs1 doubles as the vsIn history used for falling-edge detection.
   assign frameStart    = vs1 & ~vid.vsIn;
   assign activePattern = pattern;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge pixelClk) begin
      if (reset) begin
         hs1 <= 1'b1;
         vs1 <= 1'b1;
         de1 <= 1'b0;
         x1  <= '0;
         y1  <= '0;
      end else begin
         hs1 <= vid.hsIn;
         vs1 <= vid.vsIn;
         de1 <= vid.deIn;
         x1  <= vid.pixelX;
         y1  <= vid.pixelY;
      end
   end

   always_ff @(posedge pixelClk) begin
      if (reset) begin
         frameCount <= '0;
         pattern    <= PAT_BARS;
         divider    <= '0;
      end else if (frameStart) begin
         frameCount <= frameCount + 16'd1;
         if (!autoCycle) begin
            pattern <= pattern_e'(patternSel);
            divider <= '0;
         end else if (divider == DIV_W'(FRAMES_PER_PATTERN - 1)) begin
            pattern <= pattern_e'(pattern + 3'd1);
            divider <= '0;
         end else begin
            divider <= divider + 1'b1;
         end
      end
   end

   bounce_counter #(.MAX(PIXELS_H - BOX_SIZE)) u_bounce_x (
      .pixelClk (pixelClk),
      .reset    (reset),
      .step     (frameStart),
      .pos      (bx)
   );

   bounce_counter #(.MAX(PIXELS_V - BOX_SIZE)) u_bounce_y (
      .pixelClk (pixelClk),
      .reset    (reset),
      .step     (frameStart),
      .pos      (by)
   );

   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      barIdx = 3'd7;
      // Highest bound first so the smallest matching bar wins: a comparator chain, no divide.
      for (int i = 7; i >= 1; i--) begin
         if (int'(x1) < i * BAR_WIDTH) barIdx = 3'(i - 1);
      end

      inBox = ({1'b0, x1} >= {1'b0, bx}) && ({1'b0, x1} < {1'b0, bx} + 11'(BOX_SIZE)) &&
              ({1'b0, y1} >= {1'b0, by}) && ({1'b0, y1} < {1'b0, by} + 11'(BOX_SIZE));

      onBorder = (x1 == 10'd0) || (x1 == 10'(PIXELS_H - 1)) ||
                 (y1 == 10'd0) || (y1 == 10'(PIXELS_V - 1));

      colour = COL_BLACK;
      case (pattern)
         PAT_BARS:    colour = bar_colour(barIdx);
         PAT_CHECKER: colour = (x1[CHECK_LOG2] ^ y1[CHECK_LOG2]) ? COL_WHITE : COL_BLACK;
         PAT_HRAMP:   colour = {x1[9:2], x1[9:2], x1[9:2]};
         PAT_VRAMP:   colour = {y1[9:2], 16'h0000};
         PAT_BOX:     colour = inBox ? COL_WHITE : COL_BLUE;
         PAT_BORDER:  colour = onBorder ? COL_WHITE : COL_BLACK;
         PAT_WHITE:   colour = COL_WHITE;
         PAT_BLACK:   colour = COL_BLACK;
         default:     colour = COL_BLACK;
      endcase
   end

   always_ff @(posedge pixelClk) begin
      if (reset) begin
         vid.hs <= 1'b1;
         vid.vs <= 1'b1;
         vid.de <= 1'b0;
         {vid.red, vid.green, vid.blue} <= COL_BLACK;
      end else begin
         vid.hs <= hs1;
         vid.vs <= vs1;
         vid.de <= de1;
         {vid.red, vid.green, vid.blue} <= de1 ? colour : COL_BLACK;
      end
   end

endmodule
